// File: rtl/svm_cfg_loader.sv
`timescale 1ns/1ps
// Configuration sequencer for the SVM classifier: packs streamed Q4.16 coefficients into
// coefficient-RAM lines, then loads the bias. Optional readback verify: SVM_CFG_READBACK_EN.
module svm_cfg_loader #(
    parameter int FEA_I  = 4,
    parameter int FEA_F  = 16,
    parameter int N_COEF = 105,
    parameter int N_LINE = 36,
    parameter int ADDR_W = 6,
    localparam int COEF_W = FEA_I + FEA_F,
    localparam int RAM_DW = COEF_W * N_COEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [COEF_W-1:0] s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] addr_a,
    output logic              write_en,
    output logic [RAM_DW-1:0] i_data_a,
    input  logic [RAM_DW-1:0] o_data_a,
    output logic [COEF_W-1:0] bias,
    output logic              b_load,
    input  logic              dp_ready_i,
    output logic              ready,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    localparam int CNT_W = $clog2(N_COEF);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
`ifdef SVM_CFG_READBACK_EN
    localparam logic [2:0] VER1  = 3'd3;
    localparam logic [2:0] VER2  = 3'd4;
`endif
    localparam logic [2:0] BIAS  = 3'd5;
    localparam logic [2:0] BLOAD = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    logic [2:0]        state;
    logic [CNT_W-1:0]  coef_cnt;
    logic [ADDR_W-1:0] line_cnt;
    logic              accept;
    logic              last_coef;
    logic              last_line;

    // All handshake and status outputs are pure state decodes, so reset forces them to 0.
    always_comb begin
        s_ready  = (state == LOAD) || (state == BIAS);
        write_en = (state == WRITE);
        b_load   = (state == BLOAD);
        busy     = (state != IDLE) && (state != DONE);
        cfg_done = (state == DONE);
        ready    = cfg_done && dp_ready_i;
    end

    assign accept    = s_valid && s_ready;
    assign last_coef = (coef_cnt == CNT_W'(N_COEF - 1));
    assign last_line = (line_cnt == ADDR_W'(N_LINE - 1));

`ifdef SVM_CFG_READBACK_EN
    logic err_q;
    assign cfg_err = err_q;
`else
    logic unused_rd;
    assign unused_rd = ^o_data_a;
    assign cfg_err   = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            coef_cnt <= '0;
            line_cnt <= '0;
            addr_a   <= '0;
            // NOTE: the packing register drives i_data_a directly, so it is reset like any output.
            i_data_a <= '0;
            bias     <= '0;
`ifdef SVM_CFG_READBACK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= LOAD;
                        coef_cnt <= '0;
                        line_cnt <= '0;
`ifdef SVM_CFG_READBACK_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (accept) begin
                        i_data_a[coef_cnt*COEF_W +: COEF_W] <= s_data;
                        if (last_coef) begin
                            coef_cnt <= '0;
                            addr_a   <= line_cnt;
                            state    <= WRITE;
                        end else begin
                            coef_cnt <= coef_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef SVM_CFG_READBACK_EN
                WRITE: state <= VER1;
                VER1:  state <= VER2;
                VER2: begin
                    // Read data for the just-written line arrives one cycle after VER1.
                    if (o_data_a != i_data_a) err_q <= 1'b1;
                    if (last_line) begin
                        state <= BIAS;
                    end else begin
                        line_cnt <= line_cnt + ADDR_W'(1);
                        state    <= LOAD;
                    end
                end
`else
                WRITE: begin
                    if (last_line) begin
                        state <= BIAS;
                    end else begin
                        line_cnt <= line_cnt + ADDR_W'(1);
                        state    <= LOAD;
                    end
                end
`endif
                BIAS: begin
                    if (accept) begin
                        bias  <= s_data;
                        state <= BLOAD;
                    end
                end
                BLOAD:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_cfg_loader.sv
`timescale 1ns/1ps
// Self-checking bench for svm_cfg_loader: random coefficient streams against a line-packing model.
module tb_svm_cfg_loader;

    localparam int FEA_I  = 4;
    localparam int FEA_F  = 16;
    localparam int N_COEF = 105;
    localparam int N_LINE = 36;
    localparam int ADDR_W = 6;
    localparam int COEF_W = FEA_I + FEA_F;
    localparam int RAM_DW = COEF_W * N_COEF;
`ifdef SVM_CFG_READBACK_EN
    localparam int LINE_CYC = N_COEF + 3;
`else
    localparam int LINE_CYC = N_COEF + 1;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic [COEF_W-1:0] s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] addr_a;
    logic              write_en;
    logic [RAM_DW-1:0] i_data_a;
    logic [RAM_DW-1:0] o_data_a;
    logic [COEF_W-1:0] bias;
    logic              b_load;
    logic              dp_ready_i;
    logic              ready;
    logic              busy;
    logic              cfg_done;
    logic              cfg_err;

    svm_cfg_loader #(
        .FEA_I(FEA_I), .FEA_F(FEA_F), .N_COEF(N_COEF), .N_LINE(N_LINE), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .addr_a(addr_a), .write_en(write_en), .i_data_a(i_data_a),
        .o_data_a(o_data_a), .bias(bias), .b_load(b_load), .dp_ready_i(dp_ready_i),
        .ready(ready), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Coefficient RAM with 1-cycle read latency; can corrupt bit 0 of line 7.
    logic [RAM_DW-1:0] mem [0:63];
    bit corrupt = 1'b0;
    always @(posedge clk) begin
        if (write_en)
            mem[addr_a] <= (corrupt && addr_a == 7) ? {i_data_a[RAM_DW-1:1], ~i_data_a[0]} : i_data_a;
        o_data_a <= mem[addr_a];
    end

    // Observation logs, sampled mid-cycle.
    int                wr_addr_q[$];
    logic [RAM_DW-1:0] wr_data_q[$];
    int                wr_cyc_q[$];
    int                bload_cnt;
    logic [COEF_W-1:0] bload_bias;
    int                ready_viol;
    int                err_first;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (write_en === 1'b1) begin
                wr_addr_q.push_back(int'(addr_a));
                wr_data_q.push_back(i_data_a);
                wr_cyc_q.push_back(cyc);
            end
            if (b_load === 1'b1) begin
                bload_cnt  <= bload_cnt + 1;
                bload_bias <= bias;
            end
            if (cfg_done !== 1'b1 && ready !== 1'b0) ready_viol <= ready_viol + 1;
            if (cfg_done === 1'b1 && ready !== dp_ready_i) ready_viol <= ready_viol + 1;
            if (busy === 1'b1 && cfg_err === 1'b1 && err_first < 0) err_first <= cyc;
        end
    end

    // Reference model: the beats of each line, in stream order, plus the bias.
    logic [COEF_W-1:0] exp_beat [N_LINE][N_COEF];
    logic [COEF_W-1:0] exp_bias;
    int ts;
    int gap_line = -1, gap_beat = 0, gap_len = 0;
    int inj_line = -1, inj_beat = 0;
    int rst_line = -1, rst_beat = 0;
    logic post_done, post_ready, post_err, post_busy;

    function automatic logic [RAM_DW-1:0] exp_line(input int l);
        logic [RAM_DW-1:0] v;
        for (int k = 0; k < N_COEF; k++) v[k*COEF_W +: COEF_W] = exp_beat[l][k];
        return v;
    endfunction

    task automatic send_beat(input logic [COEF_W-1:0] v, input bit inj, output bit ok);
        int n;
        bit acc;
        n = 0;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data = v;
        start = inj;
        while (!ok && n < 16) begin
            acc = s_ready;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            n++;
            ok = acc;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: s_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic load_model(input bit pattern, output bit aborted);
        bit ok;
        int n;
        aborted = 1'b0;
        for (int l = 0; l < N_LINE; l++)
            for (int k = 0; k < N_COEF; k++)
                exp_beat[l][k] = pattern ? COEF_W'(l * 256 + k) : COEF_W'($urandom);
        exp_bias = pattern ? 20'h08000 : COEF_W'($urandom);
        @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        bload_cnt = 0;
        ready_viol = 0;
        err_first = -1;
        start = 1'b1;
        ts = cyc;
        @(negedge clk);
        start = 1'b0;
        post_done = cfg_done;
        post_ready = ready;
        post_err = cfg_err;
        post_busy = busy;
        for (int l = 0; l < N_LINE; l++) begin
            for (int k = 0; k < N_COEF; k++) begin
                if (l == gap_line && k == gap_beat) begin
                    s_valid = 1'b0;
                    repeat (gap_len) @(negedge clk);
                end
                if (l == rst_line && k == rst_beat) begin
                    s_valid = 1'b0;
                    rst = 1'b0;
                    #1;
                    checks++;
                    if ({s_ready, write_en, b_load, ready, busy, cfg_done, cfg_err} !== 7'b0) begin
                        errors++;
                        $display("FAIL rst_flags: got %b, required 0000000",
                                 {s_ready, write_en, b_load, ready, busy, cfg_done, cfg_err});
                    end
                    checks++;
                    if (addr_a !== '0 || bias !== '0 || i_data_a !== '0) begin
                        errors++;
                        $display("FAIL rst_regs: addr_a=%0h bias=%0h data_or=%b, required all 0",
                                 addr_a, bias, |i_data_a);
                    end
                    @(negedge clk);
                    rst = 1'b1;
                    aborted = 1'b1;
                    return;
                end
                send_beat(exp_beat[l][k], (l == inj_line && k == inj_beat), ok);
                if (!ok) begin
                    s_valid = 1'b0;
                    aborted = 1'b1;
                    return;
                end
            end
        end
        send_beat(exp_bias, 1'b0, ok);
        s_valid = 1'b0;
        n = 0;
        while (cfg_done !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (cfg_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: cfg_done=%b after %0d cycles, required 1", cfg_done, n);
        end
    endtask

    task automatic verify_model_load(input int gap_l, input int gap_n, input int err_line);
        int exp_err;
        int nw;
        logic [RAM_DW-1:0] want;
        exp_err = (err_line < 0) ? -1 : ts + N_COEF + 1 + err_line * LINE_CYC + 3;
        nw = wr_addr_q.size();
        checks++;
        if (nw != N_LINE) begin
            errors++;
            $display("FAIL write_count: got %0d, required %0d", nw, N_LINE);
        end
        for (int l = 0; l < N_LINE && l < nw; l++) begin
            want = exp_line(l);
            checks++;
            if (wr_addr_q[l] != l) begin
                errors++;
                $display("FAIL write_addr[%0d]: got %0d, required %0d", l, wr_addr_q[l], l);
            end
            checks++;
            if (wr_data_q[l] !== want) begin
                errors++;
                for (int k = 0; k < N_COEF; k++)
                    if (wr_data_q[l][k*COEF_W +: COEF_W] !== want[k*COEF_W +: COEF_W]) begin
                        $display("FAIL write_data[%0d] field %0d: got %h, required %h", l, k,
                                 wr_data_q[l][k*COEF_W +: COEF_W], want[k*COEF_W +: COEF_W]);
                        break;
                    end
            end
            checks++;
            if (wr_cyc_q[l] != ts + N_COEF + 1 + l * LINE_CYC + ((gap_l >= 0 && l >= gap_l) ? gap_n : 0)) begin
                errors++;
                $display("FAIL write_time[%0d]: got %0d, required %0d", l, wr_cyc_q[l] - ts,
                         N_COEF + 1 + l * LINE_CYC + ((gap_l >= 0 && l >= gap_l) ? gap_n : 0));
            end
        end
        checks++;
        if (bload_cnt != 1 || bload_bias !== exp_bias) begin
            errors++;
            $display("FAIL b_load: got %0d pulses bias %h, required 1 pulse bias %h", bload_cnt, bload_bias, exp_bias);
        end
        checks++;
        if (bias !== exp_bias || cfg_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_state: bias %h done %b busy %b, required %h 1 0", bias, cfg_done, busy, exp_bias);
        end
        checks++;
        if (ready_viol != 0) begin
            errors++;
            $display("FAIL ready_gate: got %0d violations, required 0", ready_viol);
        end
        checks++;
        if (err_first != exp_err || cfg_err !== (err_line >= 0)) begin
            errors++;
            $display("FAIL cfg_err: first %0d now %b, required first %0d now %b",
                     err_first < 0 ? -1 : err_first - ts, cfg_err, exp_err < 0 ? -1 : exp_err - ts, err_line >= 0);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, write_en, b_load, ready, busy, cfg_done, cfg_err} !== 7'b0 ||
            addr_a !== '0 || bias !== '0 || i_data_a !== '0) begin
            errors++;
            $display("FAIL reset_outputs: flags %b addr %0h bias %0h, required all 0",
                     {s_ready, write_en, b_load, ready, busy, cfg_done, cfg_err}, addr_a, bias);
        end
        rst = 1'b1;
        wr_addr_q.delete();
        s_valid = 1'b1;
        s_data = COEF_W'($urandom);
        repeat (6) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || s_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_start: writes %0d s_ready %b busy %b, required 0 0 0",
                     wr_addr_q.size(), s_ready, busy);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_full_load();
        bit ab;
        dp_ready_i = 1'b1;
        load_model(1'b1, ab);
        checks++;
        if (post_busy !== 1'b1 || post_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_to_load: busy %b ready %b, required 1 0", post_busy, post_ready);
        end
        verify_model_load(-1, 0, -1);
        @(negedge clk);
        #2 dp_ready_i = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_follow_low: got %b, required 0", ready);
        end
        dp_ready_i = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_follow_high: got %b, required 1", ready);
        end
    endtask

    task automatic test_stall();
        bit ab;
        gap_line = 3; gap_beat = 50; gap_len = 5;
        load_model(1'b0, ab);
        verify_model_load(3, 5, -1);
        gap_line = -1;
    endtask

    task automatic test_start_ignored();
        bit ab;
        inj_line = 10; inj_beat = 20;
        load_model(1'b0, ab);
        verify_model_load(-1, 0, -1);
        inj_line = -1;
    endtask

    task automatic test_restart_from_done();
        bit ab;
        dp_ready_i = 1'b1;
        load_model(1'b0, ab);
        checks++;
        if (post_done !== 1'b0 || post_ready !== 1'b0 || post_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_drop: done %b ready %b busy %b, required 0 0 1", post_done, post_ready, post_busy);
        end
        verify_model_load(-1, 0, -1);
    endtask

    task automatic test_reset_mid_load();
        bit ab;
        rst_line = 20; rst_beat = 30;
        load_model(1'b0, ab);
        rst_line = -1;
        checks++;
        if (ab !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort: aborted %b, required 1", ab);
        end
        wr_addr_q.delete();
        s_valid = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 0 || busy !== 1'b0 || cfg_done !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: writes %0d busy %b done %b s_ready %b, required 0 0 0 0",
                     wr_addr_q.size(), busy, cfg_done, s_ready);
        end
        s_valid = 1'b0;
        load_model(1'b0, ab);
        verify_model_load(-1, 0, -1);
    endtask

    task automatic test_readback();
        bit ab;
`ifdef SVM_CFG_READBACK_EN
        corrupt = 1'b1;
        load_model(1'b0, ab);
        verify_model_load(-1, 0, 7);
        corrupt = 1'b0;
        load_model(1'b0, ab);
        checks++;
        if (post_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_clear: got %b, required 0", post_err);
        end
        verify_model_load(-1, 0, -1);
`else
        corrupt = 1'b1;
        load_model(1'b0, ab);
        verify_model_load(-1, 0, -1);
        corrupt = 1'b0;
`endif
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        dp_ready_i = 1'b0;
        #1 rst = 1'b0;
        test_reset();
        test_full_load();
        test_stall();
        test_start_ignored();
        test_restart_from_done();
        test_reset_mid_load();
        test_readback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/svm_cfg_loader.md
Name: svm_cfg_loader

Overview:
- Configuration sequencer for the SVM classifier stage of the HOG-to-SVM pipeline.
- Streams coefficients one at a time from the host side and packs them into wide coefficient-RAM lines. Writes all 36 lines through RAM port A, then loads the bias.
- Holds the classifier's fetch `ready` low until configuration completes, so no cell data is fetched with a partially loaded model.

Parameters:
- FEA_I, 4, integer bits of coefficient/bias
- FEA_F, 16, fractional bits of coefficient/bias
- N_COEF, 105, coefficients per RAM line (15 rows x 7 cols)
- N_LINE, 36, RAM lines (block positions)
- ADDR_W, 6, RAM address width, must be >= ceil(log2(N_LINE))
- COEF_W (local), FEA_I+FEA_F = 20
- RAM_DW (local), COEF_W*N_COEF = 2100

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begin (re)configuration
- s_valid  in  1  coefficient beat valid
- s_data  in  COEF_W  coefficient or bias value, two's complement Q4.16
- s_ready  out  1  beat accepted when s_valid && s_ready
- addr_a  out  ADDR_W  coefficient RAM port A address
- write_en  out  1  RAM port A write strobe
- i_data_a  out  RAM_DW  RAM port A write data
- o_data_a  in  RAM_DW  RAM port A read data (1-cycle read latency)
- bias  out  COEF_W  bias value to classifier
- b_load  out  1  one-cycle bias load strobe
- dp_ready_i  in  1  upstream ready toward classifier fetch
- ready  out  1  gated fetch ready to classifier
- busy  out  1  configuration in progress
- cfg_done  out  1  model fully loaded
- cfg_err  out  1  sticky readback mismatch (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, counters 0, bias register 0.
- States: IDLE, LOAD, WRITE, [VERIFY], BIAS, BLOAD, DONE.
- IDLE:
  - s_ready=0, ready=0.
  - start -> LOAD; coef_cnt=0, line_cnt=0, cfg_err cleared.
- LOAD:
  - busy=1, s_ready=1.
  - Each accepted beat k (0..N_COEF-1) is placed at i_data_a[k*COEF_W +: COEF_W]. The first beat lands at the LSBs.
  - On the accept with coef_cnt=N_COEF-1 -> WRITE.
- WRITE (1 cycle):
  - s_ready=0, write_en=1, addr_a=line_cnt, i_data_a=assembled line.
  - Next state: VERIFY if the feature is enabled. Otherwise, if line_cnt=N_LINE-1 -> BIAS, else line_cnt+1 and -> LOAD.
- Line-to-line throughput: one line per N_COEF+1 cycles with s_valid held high.
- addr_a and i_data_a hold their last values outside WRITE. write_en is 1 only in WRITE.
- BIAS:
  - s_ready=1.
  - An accepted beat is latched into bias -> BLOAD.
- BLOAD (1 cycle): b_load=1 -> DONE.
- DONE:
  - busy=0, cfg_done=1, ready=dp_ready_i (combinational pass-through).
  - bias stays held until the next BIAS capture.
- In every state other than DONE: ready=0.
- start while busy: ignored. start in DONE: cfg_done=0 and ready=0 on the next cycle, -> LOAD (full reconfiguration).
- s_valid with s_ready=0: beat not consumed; the source must hold it.
- Reset mid-load: immediate return to IDLE, partially written RAM content not cleared, cfg_done=0.
- Counter widths: coef_cnt ceil(log2(N_COEF)) bits, line_cnt ADDR_W bits; neither wraps past its terminal value.

Optional Feature:
- Macro: SVM_CFG_READBACK_EN.
- With the macro: WRITE -> VERIFY (2 cycles).
  - Cycle 1: write_en=0, addr_a held.
  - Cycle 2: compare o_data_a to the written line; on mismatch, cfg_err=1 (sticky until the next start from IDLE/DONE).
  - Sequencing then continues as for WRITE. Loading proceeds regardless of errors, so line throughput is N_COEF+3 cycles.
- Without the macro: no VERIFY state, o_data_a unused, cfg_err tied 0.

Test Plan:
- Reset, then start, then 36x105 beats with s_data=line*256+k, then bias 0x0_8000:
  - 36 write_en pulses at addr 0..35, each line's field k equals line*256+k.
  - b_load pulses once with bias=0x08000; cfg_done=1; ready follows dp_ready_i.
- Drop s_valid for 5 cycles at beat 50 of line 3 -> no beat lost or duplicated; line 3 field 50 is correct; write occurs 5 cycles later than in the uninterrupted run.
- Drive dp_ready_i=1 throughout configuration -> ready=0 until the cycle cfg_done rises, then ready=1.
- Pulse start mid-LOAD on line 10 -> ignored, sequence completes normally. Then pulse start in DONE -> cfg_done/ready drop next cycle and a full reload follows.
- Assert rst low during line 20 -> all outputs 0 immediately. After release, state is IDLE and no write_en occurs until start.
- With SVM_CFG_READBACK_EN, RAM model corrupts bit 0 of line 7 -> cfg_err=1 after the line-7 verify, stays 1 through DONE, clears on the next start. With a clean RAM, cfg_err stays 0.
